booth_mul_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one sequential Booth multiplier (start/m/q in, 16-bit signed OUT) among NREQ requesters.
- Each winning request is latched, the multiplier gets a one-cycle start pulse, the block counts a fixed latency, then captures the product and returns it to the winner with a one-cycle valid.
- Sits between the requesting datapaths and the single multiplier instance; the multiplier itself is unchanged.

---
 rtl/booth_mul_arbiter_if.sv | 37 +++
 rtl/booth_mul_arbiter.sv | 134 +++++++++++++
 tb/tb_booth_mul_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/booth_mul_arbiter_if.sv
// booth_mul_arbiter_if
//   Bundles the requester-side and multiplier-side signals of booth_mul_arbiter.
//   slave  : arbiter view (drives gnt/rsp_*/busy and the multiplier inputs)
//   master : environment view (requesters plus the shared multiplier)
//   Signals:
//     req, req_m, req_q     requests and packed signed operands, slice i = [i*W +: W]
//     gnt                   one-hot acceptance pulse
//     rsp_valid, rsp_prod   one-hot result pulse and signed product
//     busy                  arbiter not in IDLE
//     mul_start, mul_m,
//     mul_q, mul_out        shared multiplier handshake
interface booth_mul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_m;
  logic [NREQ*W-1:0] req_q;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [2*W-1:0]    rsp_prod;
  logic              busy;
  logic              mul_start;
  logic [W-1:0]      mul_m;
  logic [W-1:0]      mul_q;
  logic [2*W-1:0]    mul_out;

  modport slave (
    input  req, req_m, req_q, mul_out,
    output gnt, rsp_valid, rsp_prod, busy, mul_start, mul_m, mul_q
  );

  modport master (
    output req, req_m, req_q, mul_out,
    input  gnt, rsp_valid, rsp_prod, busy, mul_start, mul_m, mul_q
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
//   Round-robin arbiter that shares one sequential Booth multiplier among NREQ
//   requesters. The winning request is latched, the multiplier gets a one-cycle
//   start pulse, a fixed MUL_LAT wait is counted, then the product is returned
//   to the winner with a one-cycle rsp_valid.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset (aborts any operation in flight)
//     bus   booth_mul_arbiter_if.slave (requester and multiplier signals)
//   Optional build macro BOOTH_ZERO_SKIP_EN: when defined, a winner with a zero
//   operand is answered directly from IDLE with product 0, bypassing the multiplier.
//
//   state | meaning
//   IDLE  | arbitrate; gnt asserted combinationally to the winner
//   LOAD  | operands on mul_m/mul_q, mul_start high for this single cycle
//   WAIT  | count MUL_LAT cycles, capture mul_out when the counter hits 0
module booth_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int MUL_LAT = 9
) (
  input logic               clk,
  input logic               rst,
  booth_mul_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   idx;
  logic            found;
  logic [W-1:0]    sel_m;
  logic [W-1:0]    sel_q;
  logic [NREQ-1:0] gnt_c;
  logic [PW-1:0]   rr_next;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_ptr) + i) % NREQ);
      if (bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    sel_m = '0;
    sel_q = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == PW'(i)) begin
        sel_m = bus.req_m[i*W +: W];
        sel_q = bus.req_q[i*W +: W];
      end
    end
  end

  assign gnt_c   = (state == IDLE && found && !rst) ? (NREQ'(1) << winner) : '0;
  assign rr_next = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;

`ifdef BOOTH_ZERO_SKIP_EN
  logic zero_op;
  assign zero_op = (sel_m == '0) || (sel_q == '0);
`endif

  assign bus.gnt  = gnt_c;
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      cnt           <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_prod  <= '0;
      bus.mul_start <= 1'b0;
      bus.mul_m     <= '0;
      bus.mul_q     <= '0;
    end else begin
      bus.rsp_valid <= '0;
      bus.mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            rr_ptr <= rr_next;
`ifdef BOOTH_ZERO_SKIP_EN
            if (zero_op) begin
              bus.rsp_prod  <= '0;
              bus.rsp_valid <= gnt_c;
            end else begin
              bus.mul_m     <= sel_m;
              bus.mul_q     <= sel_q;
              owner         <= winner;
              bus.mul_start <= 1'b1;
              state         <= LOAD;
            end
`else
            bus.mul_m     <= sel_m;
            bus.mul_q     <= sel_q;
            owner         <= winner;
            bus.mul_start <= 1'b1;
            state         <= LOAD;
`endif
          end
        end
        LOAD: begin
          cnt   <= CW'(MUL_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            bus.rsp_prod  <= bus.mul_out;
            bus.rsp_valid <= NREQ'(1) << owner;
            state         <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mul_arbiter.sv
module tb_booth_mul_arbiter;
  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int MUL_LAT = 9;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   n_fail;

  booth_mul_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  booth_mul_arbiter #(.NREQ(NREQ), .W(W), .MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sequential multiplier stand-in: product is only presented once MUL_LAT
  // cycles have elapsed after the start cycle; garbage before that.
  logic [3:0] m_cnt;
  logic       m_run;
  logic [7:0] m_a;
  logic [7:0] m_b;

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    return sa * sb;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_run <= 1'b0;
      m_cnt <= '0;
    end else if (bus.mul_start) begin
      m_a   <= bus.mul_m;
      m_b   <= bus.mul_q;
      m_cnt <= 4'(MUL_LAT - 1);
      m_run <= 1'b1;
    end else if (m_run && m_cnt != 0) begin
      m_cnt <= m_cnt - 1'b1;
    end
  end

  assign bus.mul_out = (m_run && m_cnt == 0) ? smul(m_a, m_b) : 16'hBAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request in the current cycle T, then follow it to rsp_valid at T+2+MUL_LAT.
  task automatic run_op(input logic [3:0] mask, input int idx, input logic [7:0] m,
                        input logic [7:0] q, input logic [15:0] exp, input string tag);
    logic [3:0] oh;
    int bad;
    oh = 4'b0001 << idx;
    bus.req_m = '0;
    bus.req_q = '0;
    bus.req_m[idx*8 +: 8] = m;
    bus.req_q[idx*8 +: 8] = q;
    bus.req = mask;
    #1;
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(oh));
    @(negedge clk);
    bus.req = '0;
    #1;
    chk({tag, ".start"}, 32'(bus.mul_start), 32'd1);
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    bad = 0;
    for (int k = 2; k <= MUL_LAT + 1; k++) begin
      @(negedge clk);
      #1;
      if (bus.mul_start !== 1'b0 || bus.rsp_valid !== 4'b0 || bus.busy !== 1'b1) bad++;
    end
    chk({tag, ".wait"}, 32'(bad), 32'd0);
    @(negedge clk);
    #1;
    chk({tag, ".valid"}, 32'(bus.rsp_valid), 32'(oh));
    chk({tag, ".prod"}, 32'(bus.rsp_prod), 32'(exp));
    chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [3:0]  rr_order [5];
    logic [15:0] rr_prod [5];
    n_chk  = 0;
    n_pass = 0;
    n_fail = 0;
    rst       = 1'b1;
    bus.req   = '0;
    bus.req_m = '0;
    bus.req_q = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.gnt", 32'(bus.gnt), 32'd0);
    chk("rst.valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.prod", 32'(bus.rsp_prod), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.start", 32'(bus.mul_start), 32'd0);
    chk("rst.mulmq", 32'({bus.mul_m, bus.mul_q}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle.nogrant", 32'(bus.gnt), 32'd0);

    run_op(4'b0001, 0, 8'd7, 8'd2, 16'h000E, "single");
    run_op(4'b0001, 0, 8'hF9, 8'd3, 16'hFFEB, "neg7x3");
    run_op(4'b0100, 2, 8'hD8, 8'd15, 16'hFDA8, "neg40x15");
    run_op(4'b1000, 3, 8'h80, 8'h80, 16'h4000, "min_x_min");
    run_op(4'b0010, 1, 8'h7F, 8'h80, 16'hC080, "max_x_min");

    // Abort mid-operation with a one-cycle reset at T+5.
    bus.req_m = '0;
    bus.req_q = '0;
    bus.req_m[16 +: 8] = 8'd9;
    bus.req_q[16 +: 8] = 8'd9;
    bus.req = 4'b0100;
    #1;
    chk("abort.gnt", 32'(bus.gnt), 32'b0100);
    @(negedge clk);
    bus.req = '0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort.start", 32'(bus.mul_start), 32'd0);
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.valid", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b0;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid !== 4'b0 || bus.busy !== 1'b0) bad++;
    end
    chk("abort.silent", 32'(bad), 32'd0);
    // rr_ptr back at 0: with req1 and req3 pending, req1 must win.
    run_op(4'b1010, 1, 8'd6, 8'hFC, 16'hFFE8, "after_abort");

    // Round robin with all four requesters held from reset.
    rst = 1'b1;
    bus.req_m = {8'hFB, 8'd10, 8'hFE, 8'd3};
    bus.req_q = {8'hFA, 8'hF6, 8'd9, 8'd5};
    bus.req   = 4'hF;
    @(negedge clk);
    #1;
    chk("rr.rst_gnt", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_prod  = '{16'h000F, 16'hFFEE, 16'hFF9C, 16'h001E, 16'h000F};
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr%0d.gnt", i), 32'(bus.gnt), 32'(rr_order[i]));
      for (int k = 0; k < MUL_LAT + 2; k++) begin
        @(negedge clk);
        if (i == 4) bus.req = '0;
      end
      #1;
      chk($sformatf("rr%0d.valid", i), 32'(bus.rsp_valid), 32'(rr_order[i]));
      chk($sformatf("rr%0d.prod", i), 32'(bus.rsp_prod), 32'(rr_prod[i]));
    end
    chk("rr.end_gnt", 32'(bus.gnt), 32'd0);

    // Zero operand.
`ifdef BOOTH_ZERO_SKIP_EN
    bus.req_m = '0;
    bus.req_q = '0;
    bus.req_q[7:0] = 8'd55;
    bus.req = 4'b0001;
    #1;
    chk("zero.gnt", 32'(bus.gnt), 32'b0001);
    @(negedge clk);
    bus.req = '0;
    #1;
    chk("zero.valid", 32'(bus.rsp_valid), 32'b0001);
    chk("zero.prod", 32'(bus.rsp_prod), 32'd0);
    chk("zero.start", 32'(bus.mul_start), 32'd0);
    chk("zero.busy", 32'(bus.busy), 32'd0);
`else
    run_op(4'b0001, 0, 8'd0, 8'd55, 16'h0000, "zero");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
